// File: rtl/input_conditioner_pkg.sv
// Shared types and constants for the input conditioner: per-channel debounce
// FSM state encodings and the default stability window.
package input_conditioner_pkg;

    typedef enum logic [1:0] {
        STABLE_LOW  = 2'b00,
        WAIT_HIGH   = 2'b01,
        STABLE_HIGH = 2'b10,
        WAIT_LOW    = 2'b11
    } db_state_e;

    // 5 ms at 100 MHz.
    localparam int unsigned DEFAULT_STABLE_CYCLES = 500000;

endpackage : input_conditioner_pkg

// File: rtl/input_conditioner_debounce_channel.sv
// One channel: 2-flop synchronizer, debounce FSM with stability counter and
// optional edge pulses (built only when INPUT_CONDITIONER_PULSE_EN is defined).
module debounce_channel
    import input_conditioner_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);

    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q;
    logic             s_q;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s_q     <= 1'b0;
            state_q <= STABLE_LOW;
            cnt_q   <= '0;
        end else begin
            s1_q    <= btn_in;
            s_q     <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // NOTE: defaults are assigned first so no path through the case leaves a
    // variable unassigned, which would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            STABLE_LOW: begin
                if (s_q) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_HIGH: begin
                if (!s_q) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            STABLE_HIGH: begin
                if (!s_q) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CNT_ONE;
                end
            end
            WAIT_LOW: begin
                if (s_q) begin
                    state_d = STABLE_HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE_LOW;
                cnt_d   = '0;
            end
        endcase
    end

    // The encoding puts the debounced level in the state MSB (STABLE_HIGH, WAIT_LOW).
    assign level_out = state_q[1];

`ifdef INPUT_CONDITIONER_PULSE_EN
    logic rise_q, fall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= (state_q == WAIT_HIGH) && (state_d == STABLE_HIGH);
            fall_q <= (state_q == WAIT_LOW)  && (state_d == STABLE_LOW);
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
`else
    assign rise_pulse = 1'b0;
    assign fall_pulse = 1'b0;
`endif

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// Top level: N_CH independent synchronize-and-debounce channels.
// Edge pulses are generated only when INPUT_CONDITIONER_PULSE_EN is defined.
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int unsigned N_CH          = 3,
    parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
);

    for (genvar i = 0; i < int'(N_CH); i++) begin : g_ch
        debounce_channel #(
            .STABLE_CYCLES(STABLE_CYCLES)
        ) u_ch (
            .clk       (clk),
            .reset     (reset),
            .btn_in    (btn_in[i]),
            .level_out (level_out[i]),
            .rise_pulse(rise_pulse[i]),
            .fall_pulse(fall_pulse[i])
        );
    end

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner with STABLE_CYCLES=4: vector table
// plus hand-written glitch/release sequences, checked through a scoreboard queue.
module tb_input_conditioner;

    localparam int N_CH = 3;
    localparam int SC   = 4;

`ifdef INPUT_CONDITIONER_PULSE_EN
    localparam bit PULSE_EN = 1'b1;
`else
    localparam bit PULSE_EN = 1'b0;
`endif

    typedef struct {
        logic            rst;
        logic [N_CH-1:0] btn;
        logic [N_CH-1:0] lvl;
        logic [N_CH-1:0] rise;
        logic [N_CH-1:0] fall;
    } vec_t;

    typedef struct {
        logic [N_CH-1:0] lvl;
        logic [N_CH-1:0] rise;
        logic [N_CH-1:0] fall;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N_CH-1:0] btn_in;
    logic [N_CH-1:0] level_out;
    logic [N_CH-1:0] rise_pulse;
    logic [N_CH-1:0] fall_pulse;

    int   checks   = 0;
    int   failures = 0;
    int   step_no  = 0;
    vec_t vecs[$];
    exp_t exp_q[$];

    input_conditioner #(
        .N_CH         (N_CH),
        .STABLE_CYCLES(SC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .btn_in    (btn_in),
        .level_out (level_out),
        .rise_pulse(rise_pulse),
        .fall_pulse(fall_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3*N_CH-1:0] act,
                         input logic [3*N_CH-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual(lvl,rise,fall)=%b required=%b", name, act, exp);
        end
    endtask

    function automatic void rep(input int n, input logic rst, input logic [N_CH-1:0] btn,
                                input logic [N_CH-1:0] lvl, input logic [N_CH-1:0] rise,
                                input logic [N_CH-1:0] fall);
        vec_t v;
        v.rst = rst; v.btn = btn; v.lvl = lvl; v.rise = rise; v.fall = fall;
        for (int i = 0; i < n; i++) vecs.push_back(v);
    endfunction

    // Drive one cycle of stimulus at the falling edge, record the expectation,
    // then compare at the next falling edge (after the active edge).
    task automatic step(input vec_t v);
        exp_t e;
        exp_t got;
        reset  = v.rst;
        btn_in = v.btn;
        e.lvl  = v.lvl;
        e.rise = PULSE_EN ? v.rise : '0;
        e.fall = PULSE_EN ? v.fall : '0;
        exp_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        got = exp_q.pop_front();
        check($sformatf("step%0d", step_no), {level_out, rise_pulse, fall_pulse},
              {got.lvl, got.rise, got.fall});
        step_no++;
    endtask

    initial begin
        vec_t v;

        // 1: reset with all inputs high, then rise 6 edges after release
        rep(3, 1'b1, 3'b111, 3'b000, 3'b000, 3'b000);
        rep(5, 1'b0, 3'b111, 3'b000, 3'b000, 3'b000);
        rep(1, 1'b0, 3'b111, 3'b111, 3'b111, 3'b000);
        rep(2, 1'b0, 3'b111, 3'b111, 3'b000, 3'b000);
        // back to all-low
        rep(2, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000);
        // 2: clean press on channel 0
        rep(5, 1'b0, 3'b001, 3'b000, 3'b000, 3'b000);
        rep(1, 1'b0, 3'b001, 3'b001, 3'b001, 3'b000);
        rep(3, 1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        // 3: channel 1 bounces 1,1,0 then holds 1; rise after 4 stable samples
        rep(2, 1'b0, 3'b011, 3'b001, 3'b000, 3'b000);
        rep(1, 1'b0, 3'b001, 3'b001, 3'b000, 3'b000);
        rep(5, 1'b0, 3'b011, 3'b001, 3'b000, 3'b000);
        rep(1, 1'b0, 3'b011, 3'b011, 3'b010, 3'b000);
        rep(2, 1'b0, 3'b011, 3'b011, 3'b000, 3'b000);
        // 4: release channel 0
        rep(5, 1'b0, 3'b010, 3'b011, 3'b000, 3'b000);
        rep(1, 1'b0, 3'b010, 3'b010, 3'b000, 3'b001);
        rep(2, 1'b0, 3'b010, 3'b010, 3'b000, 3'b000);
        // 5: channel 2 reaches WAIT_HIGH cnt=2, then a 1-cycle reset
        rep(4, 1'b0, 3'b110, 3'b010, 3'b000, 3'b000);
        rep(1, 1'b1, 3'b110, 3'b000, 3'b000, 3'b000);
        rep(5, 1'b0, 3'b110, 3'b000, 3'b000, 3'b000);
        rep(1, 1'b0, 3'b110, 3'b110, 3'b110, 3'b000);
        rep(2, 1'b0, 3'b110, 3'b110, 3'b000, 3'b000);

        reset  = 1'b1;
        btn_in = '0;
        for (int i = 0; i < vecs.size(); i++) step(vecs[i]);

        // One-cycle low glitch on channel 2 while stable high: no change.
        v.rst = 1'b0; v.rise = '0; v.fall = '0; v.lvl = 3'b110;
        v.btn = 3'b010;
        step(v);
        v.btn = 3'b110;
        for (int i = 0; i < 7; i++) step(v);

        // Simultaneous release of channels 1 and 2.
        v.btn = 3'b000;
        for (int i = 0; i < SC + 1; i++) step(v);
        v.lvl = 3'b000; v.fall = 3'b110;
        step(v);
        v.fall = 3'b000;
        for (int i = 0; i < 2; i++) step(v);

        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_input_conditioner
